// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, key-schedule shift amounts,
// FSM state encodings and the bit-permutation helpers used by the core and des_f.
package des_pkg;

  localparam int BLK_W    = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 28;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // All tables use DES numbering: entry value 1 refers to the MSB of the input.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFT  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: index = {row, col} = {b5, b0, b4..b1}.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] e_exp(input logic [HALF_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [2*CD_W-1:0] pc1_perm(input logic [BLK_W-1:0] x);
    logic [2*CD_W-1:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [2*CD_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [CD_W-1:0] rot28(input logic [CD_W-1:0] x, input int n,
                                            input logic right);
    logic [CD_W-1:0] y;
    case (n)
      1:       y = right ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2:       y = right ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K) = P(S1..S8(E(R) xor K)); purely combinational.
module des_f
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r,
  input  logic [SUBKEY_W-1:0] k,
  output logic [HALF_W-1:0]   f
);

  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;

  assign x = e_exp(r) ^ k;

  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] chunk;
    assign chunk = x[47-6*j -: 6];
    // Outer bits select the row, inner four the column.
    assign s[31-4*j -: 4] = 4'(SBOX[j][{chunk[5], chunk[0], chunk[4:1]}]);
  end

  assign f = p_perm(s);

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock with on-the-fly key schedule.
// Optional macro DES_DECRYPT_EN adds in_decrypt (reverse key schedule).
module des_iter_core
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16  // must not exceed 16 (shift tables have 16 entries)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  input  logic [BLK_W-1:0] in_key,
`ifdef DES_DECRYPT_EN
  input  logic             in_decrypt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  logic [1:0]          state;
  logic [HALF_W-1:0]   l, r;
  logic [CD_W-1:0]     c, d;
  logic [3:0]          rnd;
  logic                dec;
  logic [CD_W-1:0]     c_rot, d_rot;
  logic [SUBKEY_W-1:0] kr;
  logic [HALF_W-1:0]   f_out;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_ROUND);
  assign out_valid = (state == S_DONE);

  // Decrypt walks the schedule backwards: right rotation starting with zero
  // yields K16 first because C0D0 equals C16D16.
  always_comb begin
    if (dec) begin
      c_rot = rot28(c, RSHIFT[rnd], 1'b1);
      d_rot = rot28(d, RSHIFT[rnd], 1'b1);
    end else begin
      c_rot = rot28(c, SHIFT[rnd], 1'b0);
      d_rot = rot28(d, SHIFT[rnd], 1'b0);
    end
  end

  assign kr = pc2_perm({c_rot, d_rot});

  des_f u_f (
    .r (r),
    .k (kr),
    .f (f_out)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours (L <= R and R <= L ^ f rely on this).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      rnd       <= '0;
      out_block <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            {l, r} <= ip_perm(in_block);
            {c, d} <= pc1_perm(in_key);
            rnd    <= '0;
            state  <= S_ROUND;
          end
        end
        S_ROUND: begin
          c   <= c_rot;
          d   <= d_rot;
          l   <= r;
          r   <= l ^ f_out;
          rnd <= rnd + 4'd1;
          if (rnd == LAST_RND) begin
            // Final output takes the swapped halves R16 || L16.
            out_block <= fp_perm({l ^ f_out, r});
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DES_DECRYPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       dec <= 1'b0;
    else if (state == S_IDLE && in_valid) dec <= in_decrypt;
  end
`else
  assign dec = 1'b0;
`endif

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core: known-answer vectors, latency, backpressure,
// mid-operation reset, back-to-back spacing and (with DES_DECRYPT_EN) decryption.
module tb_des_iter_core;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] K3 = 64'h0000000000000000;
  localparam logic [63:0] P3 = 64'h0000000000000000;
  localparam logic [63:0] C3 = 64'h8CA64DE9C1B123A7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_block;
  logic        busy;
`ifdef DES_DECRYPT_EN
  logic        in_decrypt = 1'b0;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_iter_core #(.NUM_ROUNDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
`ifdef DES_DECRYPT_EN
    .in_decrypt(in_decrypt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  // Called at a negedge; returns #1 after the accept edge with the cycle count.
  task automatic send(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                      input logic hold, output int acc_cyc);
    wait_ready();
    in_block = blk;
    in_key   = key;
    in_valid = 1'b1;
`ifdef DES_DECRYPT_EN
    in_decrypt = dec;
`else
    if (dec) $display("decrypt request ignored in encrypt-only build");
`endif
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    // Scramble inputs: the core must have sampled them on the accept edge.
    in_block = ~blk;
    in_key   = ~key;
  endtask

  // k counts edges after the accept edge; out_valid must appear after exactly 16.
  task automatic wait_result(input logic [63:0] exp, input string tag);
    int k = 0;
    @(negedge clk);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!out_valid && k < 40) begin
      k++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(k), 64'd16);
    check(tag, out_block, exp);
  endtask

  initial begin
    int acc;
    int prev_acc;
    logic [63:0] vb [3];
    logic [63:0] vk [3];
    logic [63:0] vc [3];
    vb = '{P1, P2, P3};
    vk = '{K1, K2, K3};
    vc = '{C1, C2, C3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_block", out_block, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic encrypt
    out_ready = 1'b1;
    send(P1, K1, 1'b0, 1'b0, acc);
    wait_result(C1, "enc1");

    // Backpressure with an ignored in_valid while DONE
    @(negedge clk);
    out_ready = 1'b0;
    send(P2, K2, 1'b0, 1'b0, acc);
    wait_result(C2, "enc2");
    in_block = P1;
    in_key   = K1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_block", out_block, C2);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(C1, "enc_after_bp");

    // Reset pulse during round 7
    @(negedge clk);
    send(P2, K2, 1'b0, 1'b0, acc);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_block", out_block, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(P1, K1, 1'b0, 1'b0, acc);
    wait_result(C1, "enc_after_rst");

    // Back-to-back with in_valid held high
    @(negedge clk);
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      send(vb[i], vk[i], 1'b0, 1'b1, acc);
      if (i > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'd18);
      prev_acc = acc;
      wait_result(vc[i], "b2b");
    end
    in_valid = 1'b0;

`ifdef DES_DECRYPT_EN
    @(negedge clk);
    send(C1, K1, 1'b1, 1'b0, acc);
    wait_result(P1, "dec1");
    @(negedge clk);
    send(C3, K3, 1'b1, 1'b0, acc);
    wait_result(P3, "dec3");
    @(negedge clk);
    send(P1, K1, 1'b0, 1'b0, acc);
    wait_result(C1, "enc_after_dec");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
